win_scan_controller: RTL and testbench



---
 rtl/c4_pkg.sv | 42 ++++
 rtl/dir_window_valid.sv | 77 +++++++
 rtl/win_scan_controller.sv | 208 ++++++++++++++++++++
 tb/tb_win_scan_controller.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c4_pkg.sv
// Shared Connect Four definitions: board defaults, window direction codes,
// post-drop scan FSM states and a window-span bounds helper.
package c4_pkg;

    localparam int ROWS_DEFAULT = 6;
    localparam int COLS_DEFAULT = 7;

    // Direction codes, 1..13. Code 0 and 14..15 never describe a window.
    localparam logic [3:0] DIR_DOWN    = 4'd1;
    localparam logic [3:0] DIR_ROW_1   = 4'd2;
    localparam logic [3:0] DIR_ROW_2   = 4'd3;
    localparam logic [3:0] DIR_ROW_3   = 4'd4;
    localparam logic [3:0] DIR_ROW_4   = 4'd5;
    localparam logic [3:0] DIR_DRU_1   = 4'd6;
    localparam logic [3:0] DIR_DRU_2   = 4'd7;
    localparam logic [3:0] DIR_DRU_3   = 4'd8;
    localparam logic [3:0] DIR_DRU_4   = 4'd9;
    localparam logic [3:0] DIR_DLD_1   = 4'd10;
    localparam logic [3:0] DIR_DLD_2   = 4'd11;
    localparam logic [3:0] DIR_DLD_3   = 4'd12;
    localparam logic [3:0] DIR_DLD_4   = 4'd13;
    localparam logic [3:0] DIR_FIRST   = DIR_DOWN;
    localparam logic [3:0] DIR_LAST    = DIR_DLD_4;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_SELECT      = 3'd1,
        S_LAUNCH      = 3'd2,
        S_WAIT        = 3'd3,
        S_RELEASE     = 3'd4,
        S_RELEASE_WIN = 3'd5,
        S_FINISH      = 3'd6
    } scan_state_t;

    // A span [lo, hi] fits when it starts at or above 0 and ends at or below max_idx.
    function automatic logic span_fits(input logic signed [4:0] lo,
                                       input logic signed [4:0] hi,
                                       input logic signed [4:0] max_idx);
        return (lo >= 5'sd0) && (hi <= max_idx);
    endfunction

endpackage

// File: rtl/dir_window_valid.sv
// Combinational check that the 4-cell window of a direction, anchored on a
// board cell, lies entirely on a ROWS x COLS board.
module dir_window_valid
    import c4_pkg::*;
#(
    parameter int ROWS = ROWS_DEFAULT,
    parameter int COLS = COLS_DEFAULT
) (
    input  logic [2:0] row,
    input  logic [2:0] col,
    input  logic [3:0] direction,
    output logic       in_bounds
);

    localparam logic signed [4:0] ROW_MAX = signed'(5'(ROWS - 1));
    localparam logic signed [4:0] COL_MAX = signed'(5'(COLS - 1));

    logic signed [4:0] k_s;
    logic signed [4:0] r_lo_off_s;
    logic signed [4:0] r_hi_off_s;
    logic signed [4:0] c_lo_off_s;
    logic signed [4:0] c_hi_off_s;
    logic              dir_ok_s;
    logic signed [4:0] row_s;
    logic signed [4:0] col_s;

    // Window offsets relative to the anchor cell for each direction
    always_comb begin
        k_s        = 5'sd0;
        r_lo_off_s = 5'sd0;
        r_hi_off_s = 5'sd0;
        c_lo_off_s = 5'sd0;
        c_hi_off_s = 5'sd0;
        dir_ok_s   = 1'b0;
        case (direction)
            DIR_DOWN: begin
                r_lo_off_s = -5'sd3;
                dir_ok_s   = 1'b1;
            end
            DIR_ROW_1, DIR_ROW_2, DIR_ROW_3, DIR_ROW_4: begin
                k_s        = signed'({1'b0, direction - DIR_ROW_1}) + 5'sd1;
                c_lo_off_s = k_s - 5'sd4;
                c_hi_off_s = k_s - 5'sd1;
                dir_ok_s   = 1'b1;
            end
            DIR_DRU_1, DIR_DRU_2, DIR_DRU_3, DIR_DRU_4: begin
                k_s        = signed'({1'b0, direction - DIR_DRU_1}) + 5'sd1;
                r_lo_off_s = k_s - 5'sd4;
                r_hi_off_s = k_s - 5'sd1;
                c_lo_off_s = k_s - 5'sd4;
                c_hi_off_s = k_s - 5'sd1;
                dir_ok_s   = 1'b1;
            end
            DIR_DLD_1, DIR_DLD_2, DIR_DLD_3, DIR_DLD_4: begin
                // Column runs opposite to the row, so its span is mirrored.
                k_s        = signed'({1'b0, direction - DIR_DLD_1}) + 5'sd1;
                r_lo_off_s = k_s - 5'sd4;
                r_hi_off_s = k_s - 5'sd1;
                c_lo_off_s = 5'sd1 - k_s;
                c_hi_off_s = 5'sd4 - k_s;
                dir_ok_s   = 1'b1;
            end
            default: begin
                dir_ok_s = 1'b0;
            end
        endcase
    end

    // Widen to signed 5 bits before adding so negative offsets never wrap
    assign row_s = signed'({2'b00, row});
    assign col_s = signed'({2'b00, col});

    assign in_bounds = dir_ok_s
                     && span_fits(row_s + r_lo_off_s, row_s + r_hi_off_s, ROW_MAX)
                     && span_fits(col_s + c_lo_off_s, col_s + c_hi_off_s, COL_MAX);

endmodule

// File: rtl/win_scan_controller.sv
// Post-drop win search sequencer: walks the 13 window directions around the
// last drop, launches the direction checker on each on-board window, and
// tracks drop count, win and draw results.
module win_scan_controller
    import c4_pkg::*;
#(
    parameter int ROWS = ROWS_DEFAULT,
    parameter int COLS = COLS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       drop_valid,
    input  logic [2:0] drop_row,
    input  logic [2:0] drop_col,
    output logic       chk_start,
    output logic [2:0] chk_row,
    output logic [2:0] chk_col,
    output logic [3:0] chk_direction,
    input  logic       chk_finished,
    input  logic [1:0] chk_winner,
    output logic       busy,
    output logic       done,
    output logic       win,
    output logic [1:0] winner,
    output logic       draw,
    output logic [6:0] drop_count
);

    localparam logic [6:0] CELL_COUNT = 7'(ROWS * COLS);
    localparam logic [6:0] COUNT_MAX  = 7'd127;

    scan_state_t state_r;
    scan_state_t next_state_s;

    logic [2:0] row_r;
    logic [2:0] col_r;
    logic [3:0] dir_r;
    logic       found_r;
    logic [1:0] found_winner_r;
    logic [6:0] count_r;
    logic       win_r;
    logic [1:0] winner_r;
    logic       draw_r;
    logic       busy_r;
    logic       start_r;
    logic       done_r;

    logic       in_bounds_s;
    logic       dir_last_s;
    logic       accept_drop_s;
    logic       clear_s;

    dir_window_valid #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_dir_window_valid (
        .row       (row_r),
        .col       (col_r),
        .direction (dir_r),
        .in_bounds (in_bounds_s)
    );

    assign dir_last_s    = (dir_r == DIR_LAST);
    assign clear_s       = (state_r == S_IDLE) && new_game;
    assign accept_drop_s = (state_r == S_IDLE) && drop_valid && !new_game && !win_r;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_drop_s) next_state_s = S_SELECT;
                else               next_state_s = S_IDLE;
            end
            S_SELECT: begin
                if (in_bounds_s)     next_state_s = S_LAUNCH;
                else if (dir_last_s) next_state_s = S_FINISH;
                else                 next_state_s = S_SELECT;
            end
            S_LAUNCH: begin
                next_state_s = S_WAIT;
            end
            S_WAIT: begin
                if (chk_finished) begin
                    if (chk_winner != 2'd0) next_state_s = S_RELEASE_WIN;
                    else                    next_state_s = S_RELEASE;
                end else begin
                    next_state_s = S_WAIT;
                end
            end
            S_RELEASE: begin
                if (chk_finished)    next_state_s = S_RELEASE;
                else if (dir_last_s) next_state_s = S_FINISH;
                else                 next_state_s = S_SELECT;
            end
            S_RELEASE_WIN: begin
                // The checker is still marking the winning line until finished drops.
                if (chk_finished) next_state_s = S_RELEASE_WIN;
                else              next_state_s = S_FINISH;
            end
            S_FINISH: begin
                next_state_s = S_IDLE;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // Scan context: drop coordinates, current direction and the pending result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_r          <= 3'd0;
            col_r          <= 3'd0;
            dir_r          <= DIR_FIRST;
            found_r        <= 1'b0;
            found_winner_r <= 2'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_drop_s) begin
                        row_r          <= drop_row;
                        col_r          <= drop_col;
                        dir_r          <= DIR_FIRST;
                        found_r        <= 1'b0;
                        found_winner_r <= 2'd0;
                    end
                end
                S_SELECT: begin
                    if (!in_bounds_s && !dir_last_s) dir_r <= dir_r + 4'd1;
                end
                S_WAIT: begin
                    if (chk_finished && (chk_winner != 2'd0)) begin
                        found_r        <= 1'b1;
                        found_winner_r <= chk_winner;
                    end
                end
                S_RELEASE: begin
                    if (!chk_finished && !dir_last_s) dir_r <= dir_r + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Game-level bookkeeping; results publish on the same edge that raises done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r  <= 7'd0;
            win_r    <= 1'b0;
            winner_r <= 2'd0;
            draw_r   <= 1'b0;
        end else if (clear_s) begin
            count_r  <= 7'd0;
            win_r    <= 1'b0;
            winner_r <= 2'd0;
            draw_r   <= 1'b0;
        end else begin
            if (accept_drop_s && (count_r != COUNT_MAX)) begin
                count_r <= count_r + 7'd1;
            end
            if (next_state_s == S_FINISH) begin
                if (found_r) begin
                    win_r    <= 1'b1;
                    winner_r <= found_winner_r;
                end else if (count_r == CELL_COUNT) begin
                    draw_r <= 1'b1;
                end
            end
        end
    end

    // Registered status and strobe outputs, decoded from the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r  <= 1'b0;
            start_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            busy_r  <= (next_state_s != S_IDLE);
            start_r <= (next_state_s == S_LAUNCH);
            done_r  <= (next_state_s == S_FINISH);
        end
    end

    assign chk_start     = start_r;
    assign chk_row       = row_r;
    assign chk_col       = col_r;
    assign chk_direction = dir_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign win           = win_r;
    assign winner        = winner_r;
    assign draw          = draw_r;
    assign drop_count    = count_r;

endmodule

// File: tb/tb_win_scan_controller.sv
// Scoreboard bench for win_scan_controller with a behavioural direction-checker model.
module tb_win_scan_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       new_game = 1'b0;
    logic       drop_valid = 1'b0;
    logic [2:0] drop_row = 3'd0;
    logic [2:0] drop_col = 3'd0;
    logic       chk_start;
    logic [2:0] chk_row;
    logic [2:0] chk_col;
    logic [3:0] chk_direction;
    logic       chk_finished = 1'b0;
    logic [1:0] chk_winner = 2'd0;
    logic       busy;
    logic       done;
    logic       win;
    logic [1:0] winner;
    logic       draw;
    logic [6:0] drop_count;

    typedef struct {
        int         lat_start;
        int         lat_done;
        logic [15:0] mask;
        logic [2:0] row;
        logic [2:0] col;
        logic       win;
        logic [1:0] winner;
        logic       draw;
        logic [6:0] count;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         drop_cyc = 0;
    int         win_dir = 0;
    logic [1:0] win_player = 2'd0;

    win_scan_controller dut (
        .clk           (clk),
        .rst           (rst),
        .new_game      (new_game),
        .drop_valid    (drop_valid),
        .drop_row      (drop_row),
        .drop_col      (drop_col),
        .chk_start     (chk_start),
        .chk_row       (chk_row),
        .chk_col       (chk_col),
        .chk_direction (chk_direction),
        .chk_finished  (chk_finished),
        .chk_winner    (chk_winner),
        .busy          (busy),
        .done          (done),
        .win           (win),
        .winner        (winner),
        .draw          (draw),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Checker model: finished rises 6 cycles after the start pulse, held 1 cycle
    // (no win) or 5 cycles (win, while the winning line is written).
    initial begin : checker_model
        int m_cnt;
        int m_hold;
        m_cnt = 0;
        m_hold = 1;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_cnt = 0;
                chk_finished = 1'b0;
                chk_winner = 2'd0;
            end else if (m_cnt == 0) begin
                if (chk_start) begin
                    m_cnt = 1;
                    m_hold = (int'(chk_direction) == win_dir) ? 5 : 1;
                end
            end else begin
                m_cnt++;
                if (m_cnt >= 7 + m_hold) begin
                    m_cnt = 0;
                    chk_finished = 1'b0;
                    chk_winner = 2'd0;
                end else if (m_cnt >= 7) begin
                    chk_finished = 1'b1;
                    chk_winner = (m_hold == 5) ? win_player : 2'd0;
                end
            end
        end
    end

    // Monitor: records launches, pops and compares an expectation on every done
    initial begin : monitor
        logic [15:0] mon_mask;
        bit          start_seen;
        int          start_cyc;
        exp_t        e;
        mon_mask = 16'd0;
        start_seen = 1'b0;
        start_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_mask = 16'd0;
                start_seen = 1'b0;
            end else begin
                if (chk_start) begin
                    mon_mask[chk_direction] = 1'b1;
                    if (!start_seen) begin
                        start_seen = 1'b1;
                        start_cyc = cyc;
                    end
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_done: done with no scan pending (cycle %0d)", cyc);
                    end else begin
                        e = sb.pop_front();
                        check("done_latency", cyc - drop_cyc, e.lat_done);
                        check("first_start_latency", start_seen ? (start_cyc - drop_cyc) : -1, e.lat_start);
                        check("launch_mask", int'(mon_mask), int'(e.mask));
                        check("chk_row", int'(chk_row), int'(e.row));
                        check("chk_col", int'(chk_col), int'(e.col));
                        check("win", int'(win), int'(e.win));
                        check("winner", int'(winner), int'(e.winner));
                        check("draw", int'(draw), int'(e.draw));
                        check("drop_count", int'(drop_count), int'(e.count));
                        check("busy_at_done", int'(busy), 1);
                    end
                    mon_mask = 16'd0;
                    start_seen = 1'b0;
                end
            end
        end
    end

    task automatic run_drop(input logic [2:0] r, input logic [2:0] c,
                            input int lat_start, input int lat_done,
                            input logic [15:0] mask, input logic w,
                            input logic [1:0] wp, input logic dr,
                            input logic [6:0] cnt, input int stray_at);
        exp_t e;
        bit   seen;
        e.lat_start = lat_start;
        e.lat_done  = lat_done;
        e.mask      = mask;
        e.row       = r;
        e.col       = c;
        e.win       = w;
        e.winner    = wp;
        e.draw      = dr;
        e.count     = cnt;
        @(negedge clk);
        drop_valid = 1'b1;
        drop_row = r;
        drop_col = c;
        drop_cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        drop_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            drop_valid = (stray_at != 0) && (cyc - drop_cyc == stray_at);
            if (drop_valid) begin
                drop_row = 3'd5;
                drop_col = 3'd6;
            end
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: no done within 300 cycles of drop at cycle %0d", drop_cyc);
        end
        @(negedge clk);
        drop_valid = 1'b0;
        check("busy_after_done", int'(busy), 0);
    endtask

    task automatic pulse_new_game(input logic with_drop);
        @(negedge clk);
        new_game = 1'b1;
        drop_valid = with_drop;
        drop_row = 3'd1;
        drop_col = 3'd1;
        @(negedge clk);
        new_game = 1'b0;
        drop_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_chk_start", int'(chk_start), 0);
        check("reset_done", int'(done), 0);
        check("reset_win", int'(win), 0);
        check("reset_draw", int'(draw), 0);
        check("reset_count", int'(drop_count), 0);
        check("reset_direction", int'(chk_direction), 1);

        // Corner drop: only ROW_4 (5) and DIAG_RIGHT_UP_4 (9) fit
        run_drop(3'd0, 3'd0, 6, 30, 16'h0220, 1'b0, 2'd0, 1'b0, 7'd1, 0);
        // (2,3): DOWN and the k=1 diagonals leave the board, ten windows launch
        run_drop(3'd2, 3'd3, 3, 94, 16'h3BBC, 1'b0, 2'd0, 1'b0, 7'd2, 0);
        // Stray drop pulsed while waiting on the checker is ignored
        run_drop(3'd0, 3'd0, 6, 30, 16'h0220, 1'b0, 2'd0, 1'b0, 7'd3, 9);

        // Winner 2 on DOWN: launch in cycle 2, done at 14, no further launch
        win_dir = 1;
        win_player = 2'd2;
        run_drop(3'd3, 3'd3, 2, 14, 16'h0002, 1'b1, 2'd2, 1'b0, 7'd4, 0);
        win_dir = 0;
        win_player = 2'd0;

        // Drop after a win is ignored
        @(negedge clk);
        drop_valid = 1'b1;
        drop_row = 3'd0;
        drop_col = 3'd0;
        @(negedge clk);
        drop_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("post_win_busy", int'(busy), 0);
        check("post_win_count", int'(drop_count), 4);
        check("post_win_row", int'(chk_row), 3);

        pulse_new_game(1'b0);
        check("new_game_win", int'(win), 0);
        check("new_game_winner", int'(winner), 0);
        check("new_game_count", int'(drop_count), 0);

        // Fill the board with non-winning drops; draw rises with the 42nd done
        for (int i = 1; i <= 42; i++) begin
            run_drop(3'd0, 3'd0, 6, 30, 16'h0220, 1'b0, 2'd0, (i == 42), 7'(i), 0);
        end
        check("draw_sticky", int'(draw), 1);

        // new_game beats a simultaneous drop
        pulse_new_game(1'b1);
        check("ng_drop_busy", int'(busy), 0);
        check("ng_drop_count", int'(drop_count), 0);
        check("ng_drop_draw", int'(draw), 0);

        // Reset in the middle of WAIT
        @(negedge clk);
        drop_valid = 1'b1;
        drop_row = 3'd0;
        drop_col = 3'd0;
        drop_cyc = cyc;
        @(negedge clk);
        drop_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset_busy", int'(busy), 0);
        check("mid_reset_chk_start", int'(chk_start), 0);
        check("mid_reset_done", int'(done), 0);
        check("mid_reset_direction", int'(chk_direction), 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_drop(3'd0, 3'd0, 6, 30, 16'h0220, 1'b0, 2'd0, 1'b0, 7'd1, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
